// File: rtl/md_sequencer_if.sv
// ---------------------------------------------------------------------------
// md_sequencer_if
// Bundle between the core's control unit and the multiply/divide sequencer.
//   master : core side. It drives start/is_mult/is_unsigned/op_a/op_b for
//            MULT/MULTU/DIV/DIVU and lhr_ren/lhr_is_hi for MFHI/MFLO. It
//            receives rdata, hi, lo, busy, stall, done and div_by_zero.
//   slave  : sequencer side, with the directions reversed.
// ---------------------------------------------------------------------------
interface md_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             is_mult;
  logic             is_unsigned;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             lhr_ren;
  logic             lhr_is_hi;
  logic [WIDTH-1:0] rdata;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             stall;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start, is_mult, is_unsigned, op_a, op_b, lhr_ren, lhr_is_hi,
    input  rdata, hi, lo, busy, stall, done, div_by_zero
  );

  modport slave (
    input  start, is_mult, is_unsigned, op_a, op_b, lhr_ren, lhr_is_hi,
    output rdata, hi, lo, busy, stall, done, div_by_zero
  );
endinterface

// File: rtl/md_sequencer.sv
// ---------------------------------------------------------------------------
// md_sequencer
// Multi-cycle sequencer for MULT/MULTU/DIV/DIVU. It also owns the HI/LO pair.
// Multiply uses iterative shift-add and divide uses restoring division. Both
// work on operand magnitudes, and signs are corrected in a final FIX cycle.
// Latency is fixed: a start accepted in cycle 0 makes new HI/LO visible with
// done=1 in cycle WIDTH+3.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset. It aborts any operation in flight.
//   bus  : md_sequencer_if.slave
//          inputs : start, is_mult, is_unsigned, op_a, op_b, lhr_ren, lhr_is_hi
//          outputs: rdata (combinational HI/LO read mux), hi, lo, busy,
//                   stall, done (1-cycle pulse), div_by_zero (sticky)
// ---------------------------------------------------------------------------
module md_sequencer #(
  parameter int WIDTH = 32
) (
  input logic         clk,
  input logic         rst,
  md_sequencer_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PREP = 2'd1,
    ST_CALC = 2'd2,
    ST_FIX  = 2'd3
  } state_t;

  state_t               state_r;
  state_t               state_nxt_s;
  logic                 accept_s;

  logic [WIDTH-1:0]     a_r;
  logic [WIDTH-1:0]     b_r;
  logic                 is_mult_r;
  logic                 is_unsigned_r;
  logic [WIDTH:0]       mag_a_r;
  logic [WIDTH:0]       mag_b_r;
  logic                 neg_res_r;
  logic                 neg_rem_r;
  // Upper WIDTH+1 bits: partial product or remainder.
  // Lower WIDTH bits: multiplier or dividend, which becomes the quotient.
  logic [2*WIDTH:0]     acc_r;
  logic [CNT_W-1:0]     cnt_r;
  logic [WIDTH-1:0]     hi_r;
  logic [WIDTH-1:0]     lo_r;
  logic                 done_r;
  logic                 dbz_r;

  logic [WIDTH+1:0]     mul_sum_s;
  logic [2*WIDTH:0]     mul_next_s;
  logic [2*WIDTH:0]     div_shift_s;
  logic [WIDTH+1:0]     div_trial_s;
  logic [2*WIDTH:0]     div_next_s;
  logic [2*WIDTH-1:0]   prod_fix_s;
  logic [WIDTH-1:0]     quo_fix_s;
  logic [WIDTH-1:0]     rem_fix_s;
  logic                 div_zero_s;

  // Magnitude in WIDTH+1 bits, so that |INT_MIN| is representable.
  function automatic logic [WIDTH:0] magnitude(input logic [WIDTH-1:0] v,
                                               input logic             is_signed);
    logic [WIDTH:0] ext_v;
    ext_v = {v[WIDTH-1] & is_signed, v};
    if (is_signed && v[WIDTH-1]) begin
      magnitude = (WIDTH+1)'(0) - ext_v;
    end else begin
      magnitude = ext_v;
    end
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic and start acceptance.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          accept_s    = 1'b1;
          state_nxt_s = ST_PREP;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_PREP: state_nxt_s = ST_CALC;
      ST_CALC: begin
        if (cnt_r == CNT_W'(0)) begin
          state_nxt_s = ST_FIX;
        end else begin
          state_nxt_s = ST_CALC;
        end
      end
      ST_FIX:  state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // One iteration of each algorithm, computed from the current accumulator.
  always_comb begin
    // Multiply: conditionally add the multiplicand, then shift the whole
    // accumulator right by one.
    mul_sum_s = {1'b0, acc_r[2*WIDTH:WIDTH]} + {1'b0, mag_a_r};
    if (acc_r[0]) begin
      mul_next_s = {mul_sum_s, acc_r[WIDTH-1:1]};
    end else begin
      mul_next_s = {2'b00, acc_r[2*WIDTH:WIDTH], acc_r[WIDTH-1:1]};
    end
    // Divide: shift left, then trial-subtract the divisor from the remainder.
    div_shift_s = {acc_r[2*WIDTH-1:0], 1'b0};
    div_trial_s = {1'b0, div_shift_s[2*WIDTH:WIDTH]} - {1'b0, mag_b_r};
    if (div_trial_s[WIDTH+1]) begin
      div_next_s = div_shift_s;
    end else begin
      div_next_s = {div_trial_s[WIDTH:0], div_shift_s[WIDTH-1:1], 1'b1};
    end
  end

  // Sign correction of the final magnitudes.
  always_comb begin
    if (neg_res_r) begin
      prod_fix_s = (2*WIDTH)'(0) - acc_r[2*WIDTH-1:0];
      quo_fix_s  = WIDTH'(0) - acc_r[WIDTH-1:0];
    end else begin
      prod_fix_s = acc_r[2*WIDTH-1:0];
      quo_fix_s  = acc_r[WIDTH-1:0];
    end
    if (neg_rem_r) begin
      rem_fix_s = WIDTH'(0) - acc_r[2*WIDTH-1:WIDTH];
    end else begin
      rem_fix_s = acc_r[2*WIDTH-1:WIDTH];
    end
    div_zero_s = !is_mult_r && (b_r == WIDTH'(0));
  end

  // Datapath, HI/LO and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r           <= WIDTH'(0);
      b_r           <= WIDTH'(0);
      is_mult_r     <= 1'b0;
      is_unsigned_r <= 1'b0;
      mag_a_r       <= (WIDTH+1)'(0);
      mag_b_r       <= (WIDTH+1)'(0);
      neg_res_r     <= 1'b0;
      neg_rem_r     <= 1'b0;
      acc_r         <= (2*WIDTH+1)'(0);
      cnt_r         <= CNT_W'(0);
      hi_r          <= WIDTH'(0);
      lo_r          <= WIDTH'(0);
      done_r        <= 1'b0;
      dbz_r         <= 1'b0;
    end else begin
      done_r <= (state_r == ST_FIX);
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            a_r           <= bus.op_a;
            b_r           <= bus.op_b;
            is_mult_r     <= bus.is_mult;
            is_unsigned_r <= bus.is_unsigned;
            dbz_r         <= 1'b0;
          end
        end
        ST_PREP: begin
          mag_a_r   <= magnitude(a_r, !is_unsigned_r);
          mag_b_r   <= magnitude(b_r, !is_unsigned_r);
          neg_res_r <= !is_unsigned_r && (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
          neg_rem_r <= !is_unsigned_r && a_r[WIDTH-1];
          // Multiply iterates over the multiplier bits; divide shifts
          // dividend bits into the remainder.
          if (is_mult_r) begin
            acc_r <= {(WIDTH+1)'(0), magnitude(b_r, !is_unsigned_r)};
          end else begin
            acc_r <= {(WIDTH+1)'(0), magnitude(a_r, !is_unsigned_r)};
          end
          cnt_r <= CNT_W'(WIDTH-1);
        end
        ST_CALC: begin
          if (is_mult_r) begin
            acc_r <= mul_next_s;
          end else begin
            acc_r <= div_next_s;
          end
          if (cnt_r != CNT_W'(0)) begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        ST_FIX: begin
          if (is_mult_r) begin
            hi_r <= prod_fix_s[2*WIDTH-1:WIDTH];
            lo_r <= prod_fix_s[WIDTH-1:0];
          end else if (div_zero_s) begin
            // Division by zero has a defined result and sets a sticky flag.
            hi_r  <= a_r;
            lo_r  <= {WIDTH{1'b1}};
            dbz_r <= 1'b1;
          end else begin
            hi_r <= rem_fix_s;
            lo_r <= quo_fix_s;
          end
        end
        default: begin
          cnt_r <= CNT_W'(0);
        end
      endcase
    end
  end

  assign bus.hi          = hi_r;
  assign bus.lo          = lo_r;
  assign bus.done        = done_r;
  assign bus.div_by_zero = dbz_r;
  assign bus.busy        = (state_r != ST_IDLE);
  assign bus.stall       = (state_r != ST_IDLE) && (bus.start || bus.lhr_ren);
  assign bus.rdata       = bus.lhr_is_hi ? hi_r : lo_r;

endmodule

// File: tb/tb_md_sequencer.sv
// ---------------------------------------------------------------------------
// tb_md_sequencer
// Directed self-checking bench for md_sequencer (WIDTH = 32).
// Cycle n spans posedge n to posedge n+1. Inputs change and outputs are
// sampled on the falling edge inside each cycle.
// ---------------------------------------------------------------------------
module tb_md_sequencer;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   busy_bad;
  int   done_early;
  int   idle_bad;

  md_sequencer_if #(.WIDTH(32)) bus ();

  md_sequencer #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle 0 presents the op. Cycles 1..34 are watched. Returns at cycle 35.
  task automatic do_op(input logic m, input logic u,
                       input logic [31:0] a, input logic [31:0] b);
    busy_bad   = 0;
    done_early = 0;
    idle_bad   = 0;
    @(negedge clk);
    if (bus.busy !== 1'b0) idle_bad++;
    bus.start       = 1'b1;
    bus.is_mult     = m;
    bus.is_unsigned = u;
    bus.op_a        = a;
    bus.op_b        = b;
    for (int c = 1; c <= 34; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus.start = 1'b0;
        bus.op_a  = 32'hDEAD_BEEF;
        bus.op_b  = 32'h0000_0000;
      end
      if (bus.busy !== 1'b1) busy_bad++;
      if (bus.done !== 1'b0) done_early++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.is_mult = 1'b0; bus.is_unsigned = 1'b0;
    bus.op_a = 32'h0; bus.op_b = 32'h0;
    bus.lhr_ren = 1'b1; bus.lhr_is_hi = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.stall !== 1'b0 || bus.done !== 1'b0 ||
        bus.div_by_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: busy=%b stall=%b done=%b dbz=%b, required all 0",
               bus.busy, bus.stall, bus.done, bus.div_by_zero);
    end
    n_checks++;
    if (bus.hi !== 32'h0 || bus.lo !== 32'h0 || bus.rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_hilo: hi=%h lo=%h rdata=%h, required 0", bus.hi, bus.lo, bus.rdata);
    end
    bus.lhr_ren = 1'b0;
  endtask

  task automatic test_mult();
    do_op(1'b1, 1'b0, 32'hFFFF_FFFE, 32'h0000_0003);
    n_checks++;
    if (busy_bad != 0 || done_early != 0 || idle_bad != 0) begin
      n_fail++;
      $display("FAIL mult_timing: busy_bad=%0d done_early=%0d idle_bad=%0d, required 0",
               busy_bad, done_early, idle_bad);
    end
    n_checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mult_done: done=%b busy=%b, required 1/0", bus.done, bus.busy);
    end
    n_checks++;
    if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFFA) begin
      n_fail++;
      $display("FAIL mult_neg: hi=%h lo=%h, required ffffffff/fffffffa", bus.hi, bus.lo);
    end
    @(negedge clk);
    n_checks++;
    if (bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL done_pulse: done=%b, required 0", bus.done);
    end
    do_op(1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    n_checks++;
    if (bus.hi !== 32'hFFFF_FFFE || bus.lo !== 32'h0000_0001) begin
      n_fail++;
      $display("FAIL multu_max: hi=%h lo=%h, required fffffffe/00000001", bus.hi, bus.lo);
    end
    do_op(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    n_checks++;
    if (bus.hi !== 32'h0 || bus.lo !== 32'h0000_0001) begin
      n_fail++;
      $display("FAIL mult_m1m1: hi=%h lo=%h, required 0/1", bus.hi, bus.lo);
    end
  endtask

  task automatic test_div();
    do_op(1'b0, 1'b0, 32'hFFFF_FFF9, 32'h0000_0002);
    n_checks++;
    if (bus.lo !== 32'hFFFF_FFFD || bus.hi !== 32'hFFFF_FFFF || bus.done !== 1'b1) begin
      n_fail++;
      $display("FAIL div_neg: lo=%h hi=%h done=%b, required fffffffd/ffffffff/1",
               bus.lo, bus.hi, bus.done);
    end
    do_op(1'b0, 1'b1, 32'h0000_0007, 32'h0000_0002);
    n_checks++;
    if (bus.lo !== 32'h3 || bus.hi !== 32'h1) begin
      n_fail++;
      $display("FAIL divu_7_2: lo=%h hi=%h, required 3/1", bus.lo, bus.hi);
    end
    do_op(1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    n_checks++;
    if (bus.lo !== 32'h8000_0000 || bus.hi !== 32'h0) begin
      n_fail++;
      $display("FAIL div_intmin: lo=%h hi=%h, required 80000000/0", bus.lo, bus.hi);
    end
  endtask

  task automatic test_div_zero();
    do_op(1'b0, 1'b1, 32'h1234_5678, 32'h0000_0000);
    n_checks++;
    if (bus.lo !== 32'hFFFF_FFFF || bus.hi !== 32'h1234_5678 || bus.div_by_zero !== 1'b1 ||
        busy_bad != 0) begin
      n_fail++;
      $display("FAIL divu_zero: lo=%h hi=%h dbz=%b busy_bad=%0d, required ffffffff/12345678/1/0",
               bus.lo, bus.hi, bus.div_by_zero, busy_bad);
    end
    @(negedge clk);
    bus.start = 1'b1; bus.is_mult = 1'b1; bus.is_unsigned = 1'b1;
    bus.op_a = 32'h2; bus.op_b = 32'h3;
    @(negedge clk);
    bus.start = 1'b0;
    n_checks++;
    if (bus.div_by_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL dbz_clear: dbz=%b, required 0", bus.div_by_zero);
    end
    repeat (34) @(negedge clk);
    n_checks++;
    if (bus.lo !== 32'h6 || bus.hi !== 32'h0 || bus.done !== 1'b1) begin
      n_fail++;
      $display("FAIL multu_2_3: lo=%h hi=%h done=%b, required 6/0/1", bus.lo, bus.hi, bus.done);
    end
  endtask

  task automatic test_read_stall();
    int stall_bad;
    stall_bad = 0;
    @(negedge clk);
    // Cycle 0: the read and the start happen together in IDLE. The read sees the old LO.
    bus.start = 1'b1; bus.is_mult = 1'b1; bus.is_unsigned = 1'b0;
    bus.op_a = 32'h0001_0000; bus.op_b = 32'h0001_0000;
    bus.lhr_ren = 1'b1; bus.lhr_is_hi = 1'b0;
    #1;
    n_checks++;
    if (bus.rdata !== 32'h6 || bus.stall !== 1'b0) begin
      n_fail++;
      $display("FAIL read_same_cycle: rdata=%h stall=%b, required 6/0", bus.rdata, bus.stall);
    end
    for (int c = 1; c <= 34; c++) begin
      @(negedge clk);
      bus.start = (c == 10);
      bus.op_a  = 32'h0000_0005;
      bus.op_b  = 32'h0000_0009;
      bus.lhr_ren   = (c >= 5);
      bus.lhr_is_hi = 1'b1;
      #1;
      if (c >= 5 && bus.stall !== 1'b1) stall_bad++;
      if (c < 5 && c != 10 && bus.stall !== 1'b0) stall_bad++;
    end
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    n_checks++;
    if (stall_bad != 0) begin
      n_fail++;
      $display("FAIL stall_window: bad_cycles=%0d, required 0", stall_bad);
    end
    n_checks++;
    if (bus.stall !== 1'b0 || bus.rdata !== 32'h1 || bus.lo !== 32'h0 || bus.done !== 1'b1) begin
      n_fail++;
      $display("FAIL mfhi_after: stall=%b rdata=%h lo=%h done=%b, required 0/1/0/1",
               bus.stall, bus.rdata, bus.lo, bus.done);
    end
    @(negedge clk);
    bus.lhr_ren = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL start_ignored: busy=%b, required 0", bus.busy);
    end
  endtask

  task automatic test_back_to_back();
    // Start is held through the busy period and taken in the first IDLE cycle.
    @(negedge clk);
    bus.start = 1'b1; bus.is_mult = 1'b0; bus.is_unsigned = 1'b1;
    bus.op_a = 32'd100; bus.op_b = 32'd7;
    for (int c = 1; c <= 35; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus.is_mult = 1'b1; bus.op_a = 32'd5; bus.op_b = 32'd5;
      end
    end
    n_checks++;
    if (bus.lo !== 32'd14 || bus.hi !== 32'd2 || bus.done !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_first: lo=%0d hi=%0d done=%b, required 14/2/1", bus.lo, bus.hi, bus.done);
    end
    @(negedge clk);
    bus.start = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_accept: busy=%b, required 1", bus.busy);
    end
    repeat (34) @(negedge clk);
    n_checks++;
    if (bus.lo !== 32'd25 || bus.hi !== 32'd0 || bus.done !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_second: lo=%0d hi=%0d done=%b, required 25/0/1", bus.lo, bus.hi, bus.done);
    end
  endtask

  task automatic test_reset_abort();
    int done_seen;
    done_seen = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.is_mult = 1'b0; bus.is_unsigned = 1'b0;
    bus.op_a = 32'd100; bus.op_b = 32'd3;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_abort: busy=%b hi=%h lo=%h, required 0/0/0", bus.busy, bus.hi, bus.lo);
    end
    for (int c = 0; c < 30; c++) begin
      if (bus.done !== 1'b0) done_seen++;
      @(negedge clk);
    end
    n_checks++;
    if (done_seen != 0) begin
      n_fail++;
      $display("FAIL abort_no_done: done_cycles=%0d, required 0", done_seen);
    end
    do_op(1'b1, 1'b1, 32'd6, 32'd7);
    n_checks++;
    if (bus.lo !== 32'd42 || bus.hi !== 32'd0 || bus.done !== 1'b1 || busy_bad != 0) begin
      n_fail++;
      $display("FAIL multu_6_7: lo=%0d hi=%0d done=%b busy_bad=%0d, required 42/0/1/0",
               bus.lo, bus.hi, bus.done, busy_bad);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_read_stall();
    test_back_to_back();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
